ws2812b_frame_driver: RTL and testbench



---
 rtl/ws2812b_frame_driver.sv | 163 ++++++++++++++++
 tb/tb_ws2812b_frame_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_frame_driver.sv
// ws2812b_frame_driver: buffered GRB serialiser for a WS2812B LED chain.
// Define WS2812B_BRIGHTNESS_EN to add the global brightness scale port.
module ws2812b_frame_driver #(
  parameter int LEDCOUNT     = 36,
  parameter int CYCLES_T0H   = 38,
  parameter int CYCLES_T1H   = 77,
  parameter int CYCLES_BIT   = 120,
  parameter int CYCLES_RET   = 4800,
  parameter int FRAME_PERIOD = 960000,
  parameter int AW = (LEDCOUNT > 1) ? $clog2(LEDCOUNT) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          frame_start,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic          busy,
  output logic          frame_done,
  output logic          ws2812b_data
);

  localparam int IW = (LEDCOUNT > 1) ? $clog2(LEDCOUNT) : 1;
  localparam int CW = $clog2(CYCLES_BIT + 1);
  localparam int RW = $clog2(CYCLES_RET + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_BIT - 1);
  localparam logic [CW-1:0] T0H = CW'(CYCLES_T0H);
  localparam logic [CW-1:0] T1H = CW'(CYCLES_T1H);
  localparam logic [RW-1:0] RET_LAST = RW'(CYCLES_RET - 1);
  localparam logic [IW-1:0] LED_LAST = IW'(LEDCOUNT - 1);
  localparam logic [31:0] TMR_LOAD =
    32'((FRAME_PERIOD > 0) ? FRAME_PERIOD - 1 : 0);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, RET} state_t;

  state_t        state;
  logic [23:0]   pix_mem [LEDCOUNT];
  logic [23:0]   shreg;
  logic [23:0]   nxt;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_n;
  logic [4:0]    bit_idx;
  logic [IW-1:0] led;
  logic [IW-1:0] led_n;
  logic [RW-1:0] ret_cnt;
  logic [31:0]   tmr;
  logic          pending;
  logic          tick;

`ifdef WS2812B_BRIGHTNESS_EN
  function automatic logic [7:0] scale(
    input logic [7:0] c,
    input logic [7:0] k
  );
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, k} + 16'd1);
    return p[15:8];
  endfunction
`endif

  // Buffer holds {R,G,B}; the shifter wants G,R,B MSB first.
  function automatic logic [23:0] to_grb(input logic [23:0] rgb);
`ifdef WS2812B_BRIGHTNESS_EN
    return {scale(rgb[15:8], brightness),
            scale(rgb[23:16], brightness),
            scale(rgb[7:0], brightness)};
`else
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
`endif
  endfunction

  assign cyc_n = cyc + CW'(1);
  assign led_n = led + IW'(1);
  assign tick  = (FRAME_PERIOD > 0) && (tmr == '0);

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < 32'(LEDCOUNT)))
      pix_mem[IW'(wr_addr)] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      ws2812b_data <= 1'b0;
      pending      <= 1'b0;
      tmr          <= TMR_LOAD;
      cyc          <= '0;
      bit_idx      <= '0;
      led          <= '0;
      ret_cnt      <= '0;
      shreg        <= '0;
      nxt          <= '0;
    end else begin
      frame_done <= 1'b0;
      if (tmr == '0)
        tmr <= TMR_LOAD;
      else
        tmr <= tmr - 32'd1;
      if (tick && (state != IDLE))
        pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if (frame_start || tick || pending) begin
            state   <= FETCH;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        FETCH: begin
          shreg        <= to_grb(pix_mem[0]);
          led          <= '0;
          bit_idx      <= '0;
          cyc          <= '0;
          ws2812b_data <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          // Prefetch the next LED once, at the start of this LED.
          if ((bit_idx == 5'd0) && (cyc == '0) && (led != LED_LAST))
            nxt <= to_grb(pix_mem[led_n]);
          if (cyc != BIT_LAST) begin
            cyc          <= cyc_n;
            ws2812b_data <= cyc_n < (shreg[23] ? T1H : T0H);
          end else begin
            cyc <= '0;
            if (bit_idx != 5'd23) begin
              bit_idx      <= bit_idx + 5'd1;
              shreg        <= {shreg[22:0], 1'b0};
              ws2812b_data <= 1'b1;
            end else if (led != LED_LAST) begin
              bit_idx      <= '0;
              led          <= led_n;
              shreg        <= nxt;
              ws2812b_data <= 1'b1;
            end else begin
              state        <= RET;
              ret_cnt      <= '0;
              ws2812b_data <= 1'b0;
            end
          end
        end
        RET: begin
          if (ret_cnt == RET_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            ret_cnt <= ret_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_driver.sv
// tb_ws2812b_frame_driver: randomized frames decoded from the serial line
// and compared with a buffer model; timer instances check frame pacing.
module tb_ws2812b_frame_driver;

  localparam int N    = 2;
  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int BIT  = 6;
  localparam int RET  = 10;
  localparam int AW   = 2;
  localparam int BLEN = 1 + 24 * N * BIT + RET;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic          frame_start = 1'b0;
  logic [7:0]    brightness = 8'hFF;
  logic          busy, frame_done, ws2812b_data;
  logic          b4, d4, l4, b2, d2, l2;

  int checks = 0;
  int failures = 0;
  logic [23:0] mdl [N];
  logic [23:0] exp_px [N];

  always #5 clk = ~clk;

  ws2812b_frame_driver #(
    .LEDCOUNT(N), .CYCLES_T0H(T0H), .CYCLES_T1H(T1H),
    .CYCLES_BIT(BIT), .CYCLES_RET(RET), .FRAME_PERIOD(0), .AW(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(busy), .frame_done(frame_done),
    .ws2812b_data(ws2812b_data)
  );

  ws2812b_frame_driver #(
    .LEDCOUNT(N), .CYCLES_T0H(T0H), .CYCLES_T1H(T1H),
    .CYCLES_BIT(BIT), .CYCLES_RET(RET), .FRAME_PERIOD(400), .AW(AW)
  ) u_t400 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(1'b0),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(b4), .frame_done(d4), .ws2812b_data(l4)
  );

  ws2812b_frame_driver #(
    .LEDCOUNT(N), .CYCLES_T0H(T0H), .CYCLES_T1H(T1H),
    .CYCLES_BIT(BIT), .CYCLES_RET(RET), .FRAME_PERIOD(200), .AW(AW)
  ) u_t200 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(1'b0),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(b2), .frame_done(d2), .ws2812b_data(l2)
  );

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] grb(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
`ifdef WS2812B_BRIGHTNESS_EN
    r = (r * (int'(brightness) + 1)) / 256;
    g = (g * (int'(brightness) + 1)) / 256;
    b = (b * (int'(brightness) + 1)) / 256;
`endif
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  // Cycle index (0 = fetch cycle) at which LED a is first read.
  function automatic int fetch_first(input int a);
    return (a == 0) ? 0 : 1 + (a - 1) * 24 * BIT;
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (int'(a) < N) mdl[int'(a)] = d;
  endtask

  task automatic run_frame(
    input string tag,
    input int poke,
    input int wi,
    input logic [AW-1:0] wa,
    input logic [23:0] wd,
    input int rst_at
  );
    bit q[$];
    int n, h, base;
    bit ok;
    logic [23:0] got;
    for (int i = 0; i < N; i++) exp_px[i] = mdl[i];
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk({tag, "_lat"}, 32'(busy), 32'd1);
    n = 0;
    while (busy && n < BLEN + 5) begin
      q.push_back(ws2812b_data);
      frame_start = (n == poke);
      wr_en = (n == wi);
      wr_addr = wa;
      wr_data = wd;
      if (n == wi && int'(wa) < N) begin
        mdl[int'(wa)] = wd;
        if (n < fetch_first(int'(wa))) exp_px[int'(wa)] = wd;
      end
      resetn = !(n == rst_at);
      @(negedge clk);
      n++;
    end
    frame_start = 1'b0;
    wr_en = 1'b0;
    if (rst_at >= 0) begin
      chk({tag, "_rst_at"}, 32'(n), 32'(rst_at + 1));
      chk({tag, "_rst_line"}, 32'(ws2812b_data), 32'd0);
      chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
      resetn = 1'b1;
      return;
    end
    chk({tag, "_len"}, 32'(n), 32'(BLEN));
    chk({tag, "_done"}, 32'(frame_done), 32'd1);
    ok = (q.size() == BLEN) && (q[0] == 1'b0);
    while (q.size() < BLEN) q.push_back(1'b0);
    for (int led = 0; led < N; led++) begin
      got = '0;
      for (int b = 0; b < 24; b++) begin
        base = 1 + (led * 24 + b) * BIT;
        h = 0;
        while (h < BIT && q[base + h]) h++;
        for (int j = h; j < BIT; j++) if (q[base + j]) ok = 1'b0;
        if (h != T0H && h != T1H) ok = 1'b0;
        got = {got[22:0], (h == T1H)};
      end
      chk($sformatf("%s_px%0d", tag, led), 32'(got), 32'(grb(exp_px[led])));
    end
    for (int j = 0; j < RET; j++) if (q[1 + N * 24 * BIT + j]) ok = 1'b0;
    chk({tag, "_shape"}, 32'(ok), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int sc, pk, wi, last, nr;
    logic [AW-1:0] wa;
    bit p4, pd2;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_line", 32'(ws2812b_data), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    wr(0, 24'hFF0000);
    wr(1, 24'h0000FF);
    run_frame("basic", -1, -1, '0, '0, -1);
    run_frame("start_busy", 150, -1, '0, '0, -1);
    wr(2, 24'h123456);
    wr(3, 24'h654321);
    run_frame("bad_addr", -1, -1, '0, '0, -1);
    run_frame("wr0_late", -1, 160, 0, 24'h00FF00, -1);
    run_frame("wr0_next", -1, -1, '0, '0, -1);
    run_frame("wr1_early", -1, 0, 1, 24'hA5C3E1, -1);
    run_frame("wr0_same", -1, 0, 0, 24'h0F0F0F, -1);
    run_frame("rst_mid", -1, -1, '0, '0, 1 + 10 * BIT + 2);
    run_frame("after_rst", -1, -1, '0, '0, -1);

    wr(0, 24'hFFFFFF);
    wr(1, 24'hFFFFFF);
`ifdef WS2812B_BRIGHTNESS_EN
    brightness = 8'd128;
    run_frame("bri128", -1, -1, '0, '0, -1);
    brightness = 8'd0;
    run_frame("bri0", -1, -1, '0, '0, -1);
    brightness = 8'hFF;
`else
    run_frame("raw_white", -1, -1, '0, '0, -1);
`endif

    for (int it = 0; it < 4; it++) begin
      wr(0, 24'($urandom));
      wr(1, 24'($urandom));
`ifdef WS2812B_BRIGHTNESS_EN
      brightness = 8'($urandom);
`endif
      sc = int'($urandom_range(0, 3));
      pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BLEN - 2)) : -1;
      wa = AW'($urandom_range(0, 1));
      wi = -1;
      if (sc == 1) wi = 0;
      if (sc == 2) wi = int'($urandom_range(1 + 25 * BIT, BLEN - 1));
      if (sc == 3) begin
        wi = int'($urandom_range(10, BLEN - 1));
        wa = AW'($urandom_range(2, 3));
      end
      run_frame($sformatf("rnd%0d", it), pk, wi, wa, 24'($urandom), -1);
    end

    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    p4 = 1'b0;
    pd2 = 1'b0;
    nr = 0;
    last = 0;
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      if (b4 && !p4) begin
        if (nr > 0) chk("t400_gap", 32'(c - last), 32'd400);
        last = c;
        nr++;
      end
      p4 = b4;
      if (pd2) chk("t200_pend", 32'(b2), 32'd1);
      pd2 = d2;
    end
    chk("t400_frames", 32'(nr >= 3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
